// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready
// handshake on both sides. Operands are split into GROUP-bit lookahead groups;
// each of the STAGES register stages resolves (WIDTH/GROUP)/STAGES groups, and
// the group carry ripples from one stage to the next.
// Optional feature: define CLA_SAT_EN for signed saturation on overflow.
`timescale 1ns/1ps

module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = WIDTH / GROUP;
    localparam int GPS = NG / STAGES;
    // Number of inter-stage operand registers (at least one so arrays stay legal).
    localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;

    // Lookahead carries of one group: c[t] is the carry into bit t, c[GROUP]
    // is the group carry out (GG | GP & ci). Every carry is a flat sum of
    // products of the generate/propagate terms and the group carry-in.
    function automatic logic [GROUP:0] grp_carries(input logic [GROUP-1:0] p,
                                                   input logic [GROUP-1:0] g,
                                                   input logic             ci);
        logic [GROUP:0] c;
        logic           term;
        c = '0;
        for (int t = 0; t <= GROUP; t++) begin
            term = ci;
            for (int u = 0; u < t; u++) term = term & p[u];
            c[t] = term;
            for (int u = 0; u < t; u++) begin
                term = g[u];
                for (int w = u + 1; w < t; w++) term = term & p[w];
                c[t] = c[t] | term;
            end
        end
        return c;
    endfunction

`ifdef CLA_SAT_EN
    // Saturated result: most negative for negative operands, most positive otherwise.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return {neg, {(WIDTH-1){~neg}}};
    endfunction
`endif

    // Stage valid bits and the registered result.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    // Inter-stage registers: partial sum, propagate/generate and pending carry.
    logic [WIDTH-1:0]  p_q [NR];
    logic [WIDTH-1:0]  g_q [NR];
    logic [WIDTH-1:0]  s_q [NR];
    logic              c_q [NR];

    // Combinational next values for those registers.
    logic [WIDTH-1:0]  p_n [NR];
    logic [WIDTH-1:0]  g_n [NR];
    logic [WIDTH-1:0]  s_n [NR];
    logic              c_n [NR];

    logic [WIDTH-1:0]  fin_sum;
    logic              fin_cout;
    logic              fin_ovf;
    logic              fin_zero;

    logic [STAGES-1:0] take;   // stage k register may load this cycle
    logic [STAGES-1:0] v_src;  // valid bit feeding stage k

    // Handshake: a stage can load when it or any later stage has room, or the
    // output is draining. Depends only on state and out_ready, never on in_valid.
    always_comb begin
        logic full;
        take  = '0;
        v_src = '0;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int m = k; m < STAGES; m++) full = full & v_q[m];
            take[k]  = ~full | out_ready;
            v_src[k] = (k == 0) ? in_valid : v_q[(k == 0) ? 0 : k - 1];
        end
    end

    // Datapath: each stage resolves its share of groups from the previous stage's registers.
    always_comb begin
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] cp;
        logic [WIDTH-1:0] cg;
        logic [WIDTH-1:0] cs;
        logic             cc;
        logic             cmsb;
        logic [GROUP:0]   gc;
        int               base;
        int               pidx;
        int               ridx;

        for (int r = 0; r < NR; r++) begin
            p_n[r] = '0;
            g_n[r] = '0;
            s_n[r] = '0;
            c_n[r] = 1'b0;
        end
        fin_sum  = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        fin_zero = 1'b0;
        cmsb     = 1'b0;
        gc       = '0;

        b_eff = sub ? ~b : b;

        for (int k = 0; k < STAGES; k++) begin
            pidx = (k == 0) ? 0 : k - 1;
            ridx = (k < NR) ? k : 0;
            if (k == 0) begin
                cp = a ^ b_eff;
                cg = a & b_eff;
                cs = '0;
                cc = sub | cin;
            end else begin
                cp = p_q[pidx];
                cg = g_q[pidx];
                cs = s_q[pidx];
                cc = c_q[pidx];
            end

            for (int j = 0; j < GPS; j++) begin
                base = (k * GPS + j) * GROUP;
                gc   = grp_carries(cp[base +: GROUP], cg[base +: GROUP], cc);
                for (int t = 0; t < GROUP; t++) cs[base + t] = cp[base + t] ^ gc[t];
                cmsb = gc[GROUP-1];
                cc   = gc[GROUP];
            end

            if (k < STAGES - 1) begin
                p_n[ridx] = cp;
                g_n[ridx] = cg;
                s_n[ridx] = cs;
                c_n[ridx] = cc;
            end else begin
                fin_sum  = cs;
                fin_cout = cc;
                fin_ovf  = cmsb ^ cc;
`ifdef CLA_SAT_EN
                // On overflow both operand signs agree, so G of the MSB is that sign.
                if (fin_ovf) fin_sum = sat_value(cg[WIDTH-1]);
`endif
                fin_zero = (fin_sum == '0);
            end
        end
    end

    // Control and result registers; reset discards every in-flight item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) v_q[k] <= v_src[k];
            end
            if (take[STAGES-1] && v_src[STAGES-1]) begin
                sum_q  <= fin_sum;
                cout_q <= fin_cout;
                ovf_q  <= fin_ovf;
                zero_q <= fin_zero;
            end
        end
    end

    // Inter-stage operand registers; only loaded with valid items, no reset needed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NR; k++) begin
            if ((k < STAGES - 1) && take[k] && v_src[k]) begin
                p_q[k] <= p_n[k];
                g_q[k] <= g_n[k];
                s_q[k] <= s_n[k];
                c_q[k] <= c_n[k];
            end
        end
    end

    assign in_ready  = take[0] & rst_n;
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: directed vectors, back-pressure, mid-flight
// reset and a random sweep, all checked against an arithmetic model.
`timescale 1ns/1ps

module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic             z;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    bit   stall_v;
    res_t stall_r;
    bit   mon_en;
    bit   rand_rdy;

    // Plain-arithmetic reference: a + b_eff + carry in WIDTH+1 bits.
    function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic ci, input logic sb);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] be;
        res_t             r;
        be   = sb ? ~bv : bv;
        full = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, (sb | ci)};
        r.s  = full[WIDTH-1:0];
        r.co = full[WIDTH];
        r.ov = (av[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
`ifdef CLA_SAT_EN
        if (r.ov) r.s = av[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        r.z  = (r.s == '0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t dut_res();
        return res_t'({sum, cout, ovf, zero});
    endfunction

    // Scoreboard: hold-stability during stalls, in-order results, model push on accept.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && mon_en) begin
            if (stall_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(dut_res()), 32'(stall_r));
            end
            stall_v = out_valid && !out_ready;
            if (stall_v) stall_r = dut_res();
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected none", dut_res());
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'(dut_res()), 32'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    // Random consumer readiness during the sweep.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one item and hold it until it is accepted (bounded).
    task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb);
        bit acc;
        int n;
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL drive_timeout: got no accept expected accept within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] bpa [6];
        logic [WIDTH-1:0] bpb [6];
        int               k;
        int               n;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; mon_en = 1'b1; rand_rdy = 1'b0; stall_v = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'({out_valid, sum, cout, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Pin the model to hand-computed values.
        chk("model_add", 32'(model(16'h1234, 16'h0FCC, 1'b0, 1'b0)), 32'({16'h2200, 3'b000}));
        chk("model_carry", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h0000, 3'b101}));
        chk("model_cin", 32'(model(16'h00FF, 16'h0F00, 1'b1, 1'b0)), 32'({16'h1000, 3'b000}));
        chk("model_sub", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'({16'hFFFE, 3'b000}));
`ifdef CLA_SAT_EN
        chk("model_ovf_add", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h7FFF, 3'b010}));
        chk("model_ovf_sub", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'({16'h8000, 3'b110}));
`else
        chk("model_ovf_add", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h8000, 3'b010}));
        chk("model_ovf_sub", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'({16'h7FFF, 3'b110}));
`endif

        // Latency of the first item into an empty pipe.
        @(posedge clk);
        #1;
        drive(16'h1234, 16'h0FCC, 1'b0, 1'b0);
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(STAGES));
        chk("first_result", 32'(dut_res()), 32'({16'h2200, 3'b000}));
        wait_empty();

        // Directed vectors back to back.
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        drive(16'h00FF, 16'h0F00, 1'b1, 1'b0);
        drive(16'h1234, 16'h1234, 1'b1, 1'b1);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_empty();

        // Back-pressure: six items offered with the consumer stalled.
        for (int i = 0; i < 6; i++) begin
            bpa[i] = WIDTH'(16'h1111 * (i + 1));
            bpb[i] = WIDTH'(16'h0F0F + i);
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            a = bpa[k]; b = bpb[k]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 32'(k), 32'(STAGES));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(dut_res()), 32'(model(bpa[0], bpb[0], 1'b0, 1'b0)));
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        while (k < 6) begin
            drive(bpa[k], bpb[k], 1'b0, 1'b0);
            k++;
        end
        wait_empty();

        // Reset with two items in flight.
        out_ready = 1'b0;
        drive(16'h4321, 16'h1111, 1'b0, 1'b0);
        drive(16'h0101, 16'h0202, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sum", 32'(sum), 32'd0);
        exp_q.delete();
        stall_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Random sweep with random consumer readiness.
        @(posedge clk);
        #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Operands are split into GROUP-bit lookahead groups. Carries ripple group-to-group across STAGES register stages.
- Valid/ready handshake on both sides; supports back-pressure.
- Arithmetic primitive for the lab datapath (ALU, accumulator) where operand widths exceed 4 bits.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of GROUP.
- GROUP, 4: bits per lookahead group; internal carries are fully lookahead within a group.
- STAGES, 2: pipeline register stages. Range 1..WIDTH/GROUP; must divide WIDTH/GROUP. Each stage resolves (WIDTH/GROUP)/STAGES groups.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (ignored when sub=1)
- sub  in  1  1 = compute a-b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result bits
- cout  out  1  carry out of MSB (for subtraction: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready goes to 1 once reset is released. Reset asserted mid-operation discards every in-flight item; no partial result emerges.
- Operand conditioning: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Per bit: P=a^b_eff, G=a&b_eff. Group: GG = G[n-1] | P[n-1]&G[n-2] | ... ; GP = AND of P.
- Bit carries inside a group use full lookahead from the group carry-in. sum bit = P ^ carry.
- Group carry out = GG | GP&cin_group.
- Stage k registers: its resolved sum bits, the carry into the next unresolved group, and the unresolved operand P/G bits.
- Final stage registers sum, cout, zero, and ovf = carry into MSB ^ carry out of MSB.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Stage k advances when its successor is empty or its successor advances.
  - in_ready = !v[0] | stage0 advances. No combinational path from in_valid to in_ready.
- Latency: exactly STAGES cycles from accepted input to out_valid with no stall. Throughput is 1 result/cycle while out_ready=1.
- Stalls:
  - While out_ready=0 and out_valid=1, sum, cout, ovf and zero stay stable.
  - Stages fill behind the stalled output; in_ready falls only when all STAGES are full.
  - When out_ready rises, draining restarts the same cycle.
- Ordering: strictly in-order; no item is dropped or duplicated.
- Wrap-around: sum is modulo 2^WIDTH; the carry is reported on cout.
- Simultaneous input and output transfer with a full pipeline is legal and keeps it full.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: signed saturation. On ovf=1, sum is forced to 0x7FF..F if the operand sign (a MSB, matched with b_eff) is 0, else 0x80..0. ovf is still reported; zero is computed on the saturated value. Saturation adds no latency.
- Undefined: sum wraps modulo 2^WIDTH and ovf is flag only.

Test Plan:
- Reset/latency (WIDTH=16, STAGES=2): hold rst_n low, release. Apply a=0x1234, b=0x0FCC, cin=0, sub=0 -> 2 cycles later out_valid=1, sum=0x2200, cout=0, ovf=0, zero=0.
- Full carry propagation: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (0x7FFF with CLA_SAT_EN).
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1 (0x8000 with CLA_SAT_EN).
- Back-pressure: stream 6 back-to-back items with out_ready=0 -> in_ready drops after 2 accepts and the output holds item 1 stable. Raise out_ready -> items emerge in order, one per cycle, with no loss.
- Reset mid-flight: assert rst_n with 2 items in the pipe -> out_valid=0 immediately, and no stale result appears after release.
- Random sweep of 10k items per parameter set (GROUP=4/STAGES=1,2,4; WIDTH=8,32), with random out_ready, against a behavioural a+b+cin model.
